// File: rtl/norm_pkg.sv
// Shared types and width helpers for the stream pixel normalizer.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } norm_state_t;

  // Scale factor width: integer part covers the output range, plus fraction bits.
  function automatic int unsigned norm_scale_width(input int unsigned out_width,
                                                   input int unsigned frac_bits);
    return out_width + frac_bits;
  endfunction

  // Product width: pixel difference times scale, plus one bit of rounding headroom.
  function automatic int unsigned norm_prod_width(input int unsigned data_width,
                                                  input int unsigned out_width,
                                                  input int unsigned frac_bits);
    return data_width + out_width + frac_bits + 1;
  endfunction

endpackage

// File: rtl/norm_seq_divider.sv
// Restoring divider, one quotient bit per step; a zero divisor yields a zero quotient.
module norm_seq_divider #(
  parameter int unsigned QUOT_WIDTH = 24,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic [QUOT_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0]  divisor,
  output logic [QUOT_WIDTH-1:0] quotient
);

  logic [DIV_WIDTH-1:0]  divisor_q;
  logic [DIV_WIDTH:0]    rem_q;
  logic [QUOT_WIDTH-1:0] quot_q;
  logic                  zero_q;
  logic [DIV_WIDTH:0]    rem_shift;
  logic [DIV_WIDTH:0]    rem_sub;
  logic                  take;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    rem_shift = {rem_q[DIV_WIDTH-1:0], quot_q[QUOT_WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, divisor_q};
    // rem_q never exceeds the divisor, so its guard bit is always 0 here.
    take      = rem_q[DIV_WIDTH] | (rem_shift >= {1'b0, divisor_q});
  end

  // Divider state: load operands, then iterate while step is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor_q <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      zero_q    <= 1'b0;
    end else if (load) begin
      divisor_q <= divisor;
      rem_q     <= '0;
      quot_q    <= dividend;
      zero_q    <= (divisor == '0);
    end else if (step) begin
      rem_q  <= take ? rem_sub : rem_shift;
      quot_q <= {quot_q[QUOT_WIDTH-2:0], take};
    end
  end

  assign quotient = zero_q ? '0 : quot_q;

endmodule

// File: rtl/stream_pixel_normalizer.sv
// Streaming min/max pixel normalizer: per-channel scale computed once per frame,
// then a 2-stage clamp/subtract and multiply/shift/saturate pipeline.
// Optional build macro NORM_ROUND_EN: round half up before the final shift.
module stream_pixel_normalizer
  import norm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 8,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned ROWS       = 128,
  parameter int unsigned COLS       = 128,
  parameter int unsigned FRAC_BITS  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [CHANNELS*DATA_WIDTH-1:0] min_val,
  input  logic [CHANNELS*DATA_WIDTH-1:0] max_val,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [CHANNELS*OUT_WIDTH-1:0]  m_data,
  output logic                           m_last,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned SW    = norm_scale_width(OUT_WIDTH, FRAC_BITS);
  localparam int unsigned PW    = norm_prod_width(DATA_WIDTH, OUT_WIDTH, FRAC_BITS);
  localparam int unsigned TOTAL = ROWS * COLS;
  localparam int unsigned BCW   = $clog2(TOTAL + 1);
  localparam int unsigned CCW   = $clog2(SW + 1);

  localparam logic [OUT_WIDTH-1:0] OUT_MAX   = '1;
  localparam logic [SW-1:0]        DIVIDEND  = {OUT_MAX, {FRAC_BITS{1'b0}}};
  localparam logic [BCW-1:0]       LAST_BEAT = BCW'(TOTAL - 1);
  localparam logic [CCW-1:0]       CALC_LAST = CCW'(SW - 1);

  norm_state_t state, next_state;

  logic [CCW-1:0]        calc_cnt;
  logic [BCW-1:0]        beat_cnt;
  logic                  start_frame;
  logic                  calc_step;
  logic                  frame_end;
  logic                  advance;
  logic                  accept;

  logic [DATA_WIDTH-1:0] min_q  [CHANNELS];
  logic [DATA_WIDTH-1:0] max_q  [CHANNELS];
  logic [SW-1:0]         scale  [CHANNELS];
  logic [DATA_WIDTH-1:0] d_next [CHANNELS];
  logic [DATA_WIDTH-1:0] s1_d   [CHANNELS];
  logic [PW-1:0]         prod   [CHANNELS];
  logic                  s1_valid;
  logic                  s1_last;
  logic [CHANNELS*OUT_WIDTH-1:0] y_next;

  assign advance = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;
  assign busy    = (state != IDLE);

  // Per-channel scale dividers; a non-positive span loads a zero divisor.
  for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
    logic [DATA_WIDTH-1:0] lo, hi, span;
    assign lo   = min_val[c*DATA_WIDTH +: DATA_WIDTH];
    assign hi   = max_val[c*DATA_WIDTH +: DATA_WIDTH];
    assign span = (hi > lo) ? (hi - lo) : '0;

    norm_seq_divider #(
      .QUOT_WIDTH(SW),
      .DIV_WIDTH (DATA_WIDTH)
    ) u_div (
      .clk     (clk),
      .reset   (reset),
      .load    (start_frame),
      .step    (calc_step),
      .dividend(DIVIDEND),
      .divisor (span),
      .quotient(scale[c])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode and handshake/control strobes.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    calc_step   = 1'b0;
    frame_end   = 1'b0;
    s_ready     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          start_frame = 1'b1;
          next_state  = CALC;
        end
      end
      CALC: begin
        calc_step = 1'b1;
        if (calc_cnt == CALC_LAST) next_state = STREAM;
      end
      STREAM: begin
        s_ready = advance;
        if (s_valid && advance && (beat_cnt == LAST_BEAT)) next_state = DRAIN;
      end
      DRAIN: begin
        if (m_valid && m_ready && m_last) begin
          frame_end  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame counters, captured bounds and the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calc_cnt <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        min_q[c] <= '0;
        max_q[c] <= '0;
      end
    end else begin
      done <= frame_end;
      if (start_frame) begin
        calc_cnt <= '0;
        beat_cnt <= '0;
        for (int c = 0; c < int'(CHANNELS); c++) begin
          min_q[c] <= min_val[c*DATA_WIDTH +: DATA_WIDTH];
          max_q[c] <= max_val[c*DATA_WIDTH +: DATA_WIDTH];
        end
      end else begin
        if (calc_step) calc_cnt <= calc_cnt + CCW'(1);
        if (accept && (beat_cnt != LAST_BEAT)) beat_cnt <= beat_cnt + BCW'(1);
      end
    end
  end

  // Stage 1 combinational: clamp to [min, max] and subtract min.
  always_comb begin
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (s_data[c*DATA_WIDTH +: DATA_WIDTH] <= min_q[c])
        d_next[c] = '0;
      else if (s_data[c*DATA_WIDTH +: DATA_WIDTH] >= max_q[c])
        d_next[c] = max_q[c] - min_q[c];
      else
        d_next[c] = s_data[c*DATA_WIDTH +: DATA_WIDTH] - min_q[c];
    end
  end

  // Stage 2 combinational: multiply by scale, drop fraction, saturate.
  always_comb begin
    y_next = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      prod[c] = PW'(s1_d[c]) * PW'(scale[c]);
`ifdef NORM_ROUND_EN
      prod[c] = prod[c] + (PW'(1) << (FRAC_BITS - 1));
`endif
      prod[c] = prod[c] >> FRAC_BITS;
      y_next[c*OUT_WIDTH +: OUT_WIDTH] = (prod[c] > PW'(OUT_MAX)) ? OUT_MAX
                                                                   : prod[c][OUT_WIDTH-1:0];
    end
  end

  // Pipeline registers; everything holds while the output is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      m_data   <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) s1_d[c] <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      s1_last  <= accept && (beat_cnt == LAST_BEAT);
      if (accept) begin
        for (int c = 0; c < int'(CHANNELS); c++) s1_d[c] <= d_next[c];
      end
      m_valid <= s1_valid;
      m_last  <= s1_valid && s1_last;
      m_data  <= y_next;
    end
  end

endmodule

// File: tb/tb_stream_pixel_normalizer.sv
// Scoreboard bench for stream_pixel_normalizer (two channels, 128x128 frames).
module tb_stream_pixel_normalizer;

  localparam int unsigned DW    = 8;
  localparam int unsigned OW    = 8;
  localparam int unsigned CH    = 2;
  localparam int unsigned ROWS  = 128;
  localparam int unsigned COLS  = 128;
  localparam int unsigned FB    = 16;
  localparam int unsigned SW    = OW + FB;
  localparam int unsigned TOTAL = ROWS * COLS;
  localparam int unsigned YMAX  = (1 << OW) - 1;
`ifdef NORM_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   min_val = '0;
  logic [15:0]   max_val = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [15:0]   s_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [15:0]   m_data;
  logic          m_last;
  logic          busy;
  logic          done;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          pop_cnt = 0;
  int          rprob = 100;
  int unsigned bmin[2];
  int unsigned bmax[2];
  logic        stall_pend = 1'b0;
  logic [15:0] stall_data;
  logic        stall_last;

  stream_pixel_normalizer #(
    .DATA_WIDTH(DW), .OUT_WIDTH(OW), .CHANNELS(CH),
    .ROWS(ROWS), .COLS(COLS), .FRAC_BITS(FB)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .min_val(min_val), .max_val(max_val),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference normalizer written straight from the arithmetic definition.
  function automatic int unsigned norm_ref(input int unsigned x, input int unsigned mn,
                                           input int unsigned mx);
    longint unsigned sc, xc, p;
    if (mx <= mn) return 0;
    sc = (64'(YMAX) << FB) / 64'(mx - mn);
    xc = (x < mn) ? 64'(mn) : (x > mx) ? 64'(mx) : 64'(x);
    p  = (xc - 64'(mn)) * sc;
    if (ROUND) p = p + (64'(1) << (FB - 1));
    p = p >> FB;
    return (p > 64'(YMAX)) ? YMAX : 32'(p);
  endfunction

  function automatic logic [15:0] gen_pix(input int mode, input int i);
    logic [7:0] c0, c1;
    c1 = 8'($urandom);
    case (mode)
      0: c0 = 8'(i % 256);
      1: begin
        case (i)
          0:       c0 = 8'd100;
          1:       c0 = 8'd30;
          2:       c0 = 8'd200;
          default: c0 = 8'($urandom);
        endcase
      end
      default: c0 = 8'($urandom);
    endcase
    return {c1, c0};
  endfunction

  function automatic logic [7:0] exp_ch0(input int mode, input int i, input int unsigned x);
    case (mode)
      0: return 8'(x);
      1: begin
        if (i == 0 || i == 2) return ROUND ? 8'd255 : 8'd254;
        else if (i == 1)      return 8'd0;
        else                  return 8'(norm_ref(x, bmin[0], bmax[0]));
      end
      default: return 8'(norm_ref(x, bmin[0], bmax[0]));
    endcase
  endfunction

  // Downstream ready pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(99) < rprob);
    end
  end

  // Monitor: compare every output beat with the scoreboard, check stall stability.
  always @(negedge clk) begin
    if (reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, stall_data);
        chk("stall_last", m_last, stall_last);
      end
      stall_pend = m_valid && !m_ready;
      stall_data = m_data;
      stall_last = m_last;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: data %0d with empty scoreboard at %0t", m_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", m_data, mon_e.data);
          chk("beat_last", m_last, mon_e.last);
          pop_cnt++;
        end
      end
      if (done) done_cnt++;
    end
  end

  // Watchdog against a hung handshake.
  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, %0d checks %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic start_frame(input int unsigned mn0, input int unsigned mx0,
                             input int unsigned mn1, input int unsigned mx1);
    bmin[0] = mn0; bmax[0] = mx0; bmin[1] = mn1; bmax[1] = mx1;
    @(posedge clk); #1;
    min_val = {8'(mn1), 8'(mn0)};
    max_val = {8'(mx1), 8'(mx0)};
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    min_val = 16'($urandom);
    max_val = 16'($urandom);
    for (int k = 0; k < int'(SW); k++) begin
      @(negedge clk);
      chk("calc_s_ready", s_ready, 0);
      if (k == 0) chk("calc_busy", busy, 1);
      @(posedge clk); #1;
      start = (k == 4);
    end
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int mode, input int vprob, input int start_at);
    int   i;
    bit   take;
    bit   pulsed;
    exp_t e;
    i = 0;
    pulsed = 1'b0;
    while (i < n) begin
      if (!s_valid && ($urandom_range(99) < vprob)) begin
        s_valid = 1'b1;
        s_data  = gen_pix(mode, i);
      end
      start = 1'b0;
      if (start_at >= 0 && i == start_at && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      @(negedge clk);
      take = s_valid && s_ready;
      if (take) begin
        e.data = {8'(norm_ref(32'(s_data[15:8]), bmin[1], bmax[1])),
                  exp_ch0(mode, i, 32'(s_data[7:0]))};
        e.last = (i == int'(TOTAL) - 1);
        exp_q.push_back(e);
        i++;
      end
      @(posedge clk); #1;
      if (take) s_valid = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic finish_frame(input int d0, input int p0);
    int k;
    k = 0;
    while ((done_cnt == d0 || exp_q.size() != 0) && k < 5000) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk("frame_complete", (k < 5000), 1);
    chk("done_pulses", done_cnt - d0, 1);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("beats_out", pop_cnt - p0, TOTAL);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int d0, p0;
    int unsigned a0, b0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Full range identity on ch0 with random stalls on both sides.
    rprob = 80;
    d0 = done_cnt; p0 = pop_cnt;
    start_frame(0, 255, 32'($urandom_range(0, 120)), 32'($urandom_range(121, 255)));
    send_beats(TOTAL, 0, 90, -1);
    finish_frame(d0, p0);

    // Ch0 min 50 / max 100 corner pixels, ch1 flat bounds; start ignored mid-stream.
    rprob = 100;
    d0 = done_cnt; p0 = pop_cnt;
    start_frame(50, 100, 40, 40);
    send_beats(TOTAL, 1, 100, 1000);
    finish_frame(d0, p0);

    // Abort a frame with reset in the middle of streaming.
    rprob = 70;
    d0 = done_cnt;
    start_frame(10, 200, 0, 255);
    send_beats(300, 3, 100, -1);
    #2;
    reset   = 1'b1;
    s_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_m_valid", m_valid, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_m_data", m_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);

    // Fresh frame after the abort: random ch0 bounds, inverted ch1 bounds.
    rprob = 100;
    a0 = $urandom_range(0, 100);
    b0 = $urandom_range(150, 255);
    d0 = done_cnt; p0 = pop_cnt;
    start_frame(a0, b0, 200, 10);
    send_beats(TOTAL, 4, 100, -1);
    finish_frame(d0, p0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
